// File: rtl/adc_ascii_framer.sv
// rtl/adc_ascii_framer.sv - periodic ADC sample to ASCII decimal frame ("ddd\r\n") for a UART
module adc_ascii_framer #(
   parameter int PERIOD = 10000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] sample,
   input  logic       sample_valid,
   output logic [7:0] tx_data,
   output logic       tx_en,
   input  logic       tx_done,
   output logic       busy,
   output logic       frame_drop
);

   localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CONV = 3'd1,
      LOAD = 3'd2,
      SEND = 3'd3,
      GAP  = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q;
   logic          tc;
   logic [7:0]    hold_q, hold_d;
   logic          fresh_q, fresh_d;
   logic [7:0]    sh_q, sh_d;
   logic [11:0]   bcd_q, bcd_d;
   logic [11:0]   bcd_adj;
   logic [2:0]    cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          tx_en_q, tx_en_d;
   logic          busy_q, busy_d;
   logic          frame_drop_q, frame_drop_d;

   // Byte idx of the frame: three ASCII digits (leading zeros kept), then CR, LF.
   function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [11:0] bcd);
      case (idx)
         3'd0:    frame_byte = {4'h3, bcd[11:8]};
         3'd1:    frame_byte = {4'h3, bcd[7:4]};
         3'd2:    frame_byte = {4'h3, bcd[3:0]};
         3'd3:    frame_byte = 8'h0D;
         default: frame_byte = 8'h0A;
      endcase
   endfunction

   assign tc = (timer_q == TW'(PERIOD - 1));

   // Free-running frame timer; wraps at PERIOD-1 regardless of FSM state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_q <= '0;
      end else if (tc) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_q + TW'(1);
      end
   end

   // Double-dabble correction: add 3 to every BCD digit >= 5 before the next shift.
   always_comb begin
      bcd_adj = bcd_q;
      if (bcd_q[3:0]  >= 4'd5) bcd_adj[3:0]  = bcd_q[3:0]  + 4'd3;
      if (bcd_q[7:4]  >= 4'd5) bcd_adj[7:4]  = bcd_q[7:4]  + 4'd3;
      if (bcd_q[11:8] >= 4'd5) bcd_adj[11:8] = bcd_q[11:8] + 4'd3;
   end

   // Next-state logic: sample capture, frame start, conversion, byte handshaking, drop detection.
   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      fresh_d      = fresh_q;
      sh_d         = sh_q;
      bcd_d        = bcd_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      tx_data_d    = tx_data_q;
      tx_en_d      = tx_en_q;
      frame_drop_d = 1'b0;

      if (sample_valid) begin
         hold_d  = sample;
         fresh_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (tc && fresh_q) begin
               // The same-cycle sample is newer than the held one, so it wins.
               sh_d    = sample_valid ? sample : hold_q;
               fresh_d = 1'b0;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = CONV;
            end
         end
         CONV: begin
            bcd_d = {bcd_adj[10:0], sh_q[7]};
            sh_d  = {sh_q[6:0], 1'b0};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            idx_d     = 3'd0;
            tx_data_d = frame_byte(3'd0, bcd_q);
            tx_en_d   = 1'b1;
            state_d   = SEND;
         end
         SEND: begin
            if (tx_done) begin
               tx_en_d = 1'b0;
               if (idx_q == 3'd4) begin
                  state_d = IDLE;
               end else begin
                  idx_d     = idx_q + 3'd1;
                  tx_data_d = frame_byte(idx_q + 3'd1, bcd_q);
                  state_d   = GAP;
               end
            end
         end
         GAP: begin
            tx_en_d = 1'b1;
            state_d = SEND;
         end
         default: begin
            tx_en_d = 1'b0;
            state_d = IDLE;
         end
      endcase

      // A frame slot that arrives while a frame is still going out is skipped, not queued.
      if (tc && (state_q != IDLE)) begin
         frame_drop_d = 1'b1;
      end

      busy_d = (state_d != IDLE);
   end

   // State and output registers; reset aborts any frame in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         hold_q       <= '0;
         fresh_q      <= 1'b0;
         sh_q         <= '0;
         bcd_q        <= '0;
         cnt_q        <= '0;
         idx_q        <= '0;
         tx_data_q    <= '0;
         tx_en_q      <= 1'b0;
         busy_q       <= 1'b0;
         frame_drop_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         fresh_q      <= fresh_d;
         sh_q         <= sh_d;
         bcd_q        <= bcd_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         tx_data_q    <= tx_data_d;
         tx_en_q      <= tx_en_d;
         busy_q       <= busy_d;
         frame_drop_q <= frame_drop_d;
      end
   end

   assign tx_data    = tx_data_q;
   assign tx_en      = tx_en_q;
   assign busy       = busy_q;
   assign frame_drop = frame_drop_q;

endmodule

// File: tb/tb_adc_ascii_framer.sv
// tb/tb_adc_ascii_framer.sv - directed self-checking bench for adc_ascii_framer
module tb_adc_ascii_framer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] sample = 8'h00;
   logic       sample_valid = 1'b0;
   logic [7:0] tx_data;
   logic       tx_en;
   logic       tx_done = 1'b0;
   logic       busy;
   logic       frame_drop;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc;
   int en_cnt   = 0;
   int busy_cnt = 0;
   int drop_cnt = 0;

   logic [7:0] got [5];

   adc_ascii_framer #(.PERIOD(64)) dut (
      .clk          (clk),
      .rst          (rst),
      .sample       (sample),
      .sample_valid (sample_valid),
      .tx_data      (tx_data),
      .tx_en        (tx_en),
      .tx_done      (tx_done),
      .busy         (busy),
      .frame_drop   (frame_drop)
   );

   always #5 clk = ~clk;

   // Edges since reset release: edge k leaves the timer at k mod 64.
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   always @(posedge clk) begin
      if (tx_en)      en_cnt   <= en_cnt + 1;
      if (busy)       busy_cnt <= busy_cnt + 1;
      if (frame_drop) drop_cnt <= drop_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
      n_checks++;
      if (got_v === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_tx_en(output bit seen);
      int n = 0;
      while (!tx_en && n < 300) begin
         tick();
         n++;
      end
      seen = tx_en;
   endtask

   task automatic pulse_sample(input logic [7:0] v);
      sample       = v;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
   endtask

   // Serve nbytes bytes: tx_done arrives delay cycles after each tx_en rise.
   task automatic run_frame(input int delay, input int nbytes, input int inj,
                            input logic [7:0] inj_val, input bit hold2);
      bit seen;
      bit stable  = 1'b1;
      bit gap_ok  = 1'b1;
      bit end_bsy = 1'b0;
      for (int i = 0; i < nbytes; i++) begin
         wait_tx_en(seen);
         if (!seen) begin
            check("tx_en_timeout", 32'd0, 32'd1);
            return;
         end
         got[i] = tx_data;
         for (int d = 0; d < delay - 1; d++) begin
            if (i == inj && d == 0) begin
               sample       = inj_val;
               sample_valid = 1'b1;
            end
            tick();
            sample_valid = 1'b0;
            if (!tx_en || tx_data !== got[i]) stable = 1'b0;
         end
         tx_done = 1'b1;
         tick();
         if (tx_en) gap_ok = 1'b0;
         if (i == 4) end_bsy = busy;
         if (hold2) tick();
         tx_done = 1'b0;
      end
      check("tx_hold_stable", {31'd0, stable}, 32'd1);
      check("tx_en_low_after_done", {31'd0, gap_ok}, 32'd1);
      if (nbytes == 5) check("busy_after_last_done", {31'd0, end_bsy}, 32'd0);
   endtask

   task automatic check_frame(input string tag, input logic [39:0] exp_f);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("%s_byte%0d", tag, i), {24'd0, got[i]}, {24'd0, exp_f[39 - 8*i -: 8]});
      end
   endtask

   initial begin
      bit seen;
      int e0, b0, d0;

      // Reset state
      repeat (3) tick();
      check("rst_tx_data", {24'd0, tx_data}, 32'h00);
      check("rst_tx_en", {31'd0, tx_en}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_frame_drop", {31'd0, frame_drop}, 32'd0);
      rst = 1'b0;

      // 0xFF -> "255\r\n", first tx_en 10 cycles after the tc at edge 63
      repeat (4) tick();
      pulse_sample(8'hFF);
      d0 = drop_cnt;
      wait_tx_en(seen);
      check("first_tx_en_cycle", cyc, 32'd73);
      run_frame(20, 5, 9, 8'h00, 1'b0);
      check_frame("f255", 40'h3235350D0A);
      check("f255_drops", drop_cnt - d0, 32'd1);

      // 0x00 -> "000\r\n"; tx_done held through GAP must not skip a byte
      tick();
      pulse_sample(8'h00);
      d0 = drop_cnt;
      run_frame(5, 5, 9, 8'h00, 1'b1);
      check_frame("f000", 40'h3030300D0A);
      check("f000_drops", drop_cnt - d0, 32'd0);

      // Three periods with no sample: stray tx_done pulses change nothing
      e0 = en_cnt; b0 = busy_cnt; d0 = drop_cnt;
      for (int i = 0; i < 192; i++) begin
         tx_done = (i % 50 == 7);
         tick();
      end
      tx_done = 1'b0;
      check("idle_tx_en", en_cnt - e0, 32'd0);
      check("idle_busy", busy_cnt - b0, 32'd0);
      check("idle_drops", drop_cnt - d0, 32'd0);

      // Slow transmitter: three tc slots fall mid-frame, frame intact, no restart after
      d0 = drop_cnt;
      pulse_sample(8'h80);
      run_frame(40, 5, 9, 8'h00, 1'b0);
      check_frame("f128", 40'h3132380D0A);
      check("f128_drops", drop_cnt - d0, 32'd3);
      e0 = en_cnt;
      repeat (130) tick();
      check("no_restart_tx_en", en_cnt - e0, 32'd0);

      // New sample during byte 2 affects only the next frame
      pulse_sample(8'h05);
      run_frame(10, 5, 1, 8'h7B, 1'b0);
      check_frame("f005", 40'h3030350D0A);
      run_frame(10, 5, 9, 8'h00, 1'b0);
      check_frame("f123", 40'h3132330D0A);

      // Reset during byte 3 aborts at once and the frame never resumes
      pulse_sample(8'hC8);
      run_frame(5, 2, 9, 8'h00, 1'b0);
      check_frame_partial: begin
         check("abort_b0", {24'd0, got[0]}, 32'h32);
         check("abort_b1", {24'd0, got[1]}, 32'h30);
      end
      wait_tx_en(seen);
      check("abort_b2_data", {24'd0, tx_data}, 32'h30);
      #2 rst = 1'b1;
      #1;
      check("abort_tx_en", {31'd0, tx_en}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_tx_data", {24'd0, tx_data}, 32'h00);
      repeat (3) tick();
      rst = 1'b0;
      e0 = en_cnt; b0 = busy_cnt; d0 = drop_cnt;
      repeat (130) tick();
      check("post_rst_tx_en", en_cnt - e0, 32'd0);
      check("post_rst_busy", busy_cnt - b0, 32'd0);
      check("post_rst_drops", drop_cnt - d0, 32'd0);

      // Timer restarted at reset release: tc at edge 191, tx_en at 201
      pulse_sample(8'h2A);
      wait_tx_en(seen);
      check("post_rst_tx_en_cycle", cyc, 32'd201);
      run_frame(5, 5, 9, 8'h00, 1'b0);
      check_frame("f042", 40'h3034320D0A);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
